// File: rtl/grey_code_pipe.sv
// grey_code_pipe: pipelined bidirectional binary<->Gray converter with valid/ready on both sides.
// The Gray->binary prefix-XOR chain is cut into STAGES MSB-first slices, one slice resolved per stage.
// Optional build macro GREY_ADJ_CHECK_EN adds a sticky adj_err output flagging Gray->binary input
// words that differ from the previous Gray->binary input word in more than one bit.
module grey_code_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_mode,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_mode
`ifdef GREY_ADJ_CHECK_EN
    ,
    output logic             adj_err
`endif
);

    localparam int unsigned SLICE = (WIDTH + STAGES - 1) / STAGES;

    logic             valid_q  [STAGES];
    logic             mode_q   [STAGES];
    logic [WIDTH-1:0] data_q   [STAGES];

    logic             in_valid [STAGES];
    logic             in_mode  [STAGES];
    logic [WIDTH-1:0] in_data  [STAGES];
    logic [WIDTH-1:0] out_data [STAGES];
    logic             load     [STAGES];

    // Stage inputs: stage 0 takes the input port, later stages take the previous register.
    always_comb begin
        in_valid[0] = s_valid;
        in_mode[0]  = s_mode;
        in_data[0]  = s_data;
        for (int k = 1; k < int'(STAGES); k++) begin
            in_valid[k] = valid_q[k-1];
            in_mode[k]  = mode_q[k-1];
            in_data[k]  = data_q[k-1];
        end
    end

    // A stage loads when it, or every stage after it, can make room (bubbles collapse).
    always_comb begin
        logic full;
        full = 1'b1;
        for (int k = 0; k < int'(STAGES); k++) begin
            full = 1'b1;
            for (int j = k; j < int'(STAGES); j++) begin
                full = full & valid_q[j];
            end
            load[k] = m_ready | ~full;
        end
    end

    // Per-stage conversion: B->G entirely in stage 0; G->B resolves one slice per stage,
    // seeded by the already-resolved bit just above the slice.
    always_comb begin
        int hi;
        int lo;
        hi = 0;
        lo = 0;
        for (int k = 0; k < int'(STAGES); k++) begin
            out_data[k] = in_data[k];
            hi = int'(WIDTH) - 1 - k * int'(SLICE);
            lo = int'(WIDTH) - (k + 1) * int'(SLICE);
            if (in_mode[k]) begin
                for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
                    if (i <= hi && i >= lo) begin
                        out_data[k][i] = out_data[k][i+1] ^ in_data[k][i];
                    end
                end
            end else if (k == 0) begin
                out_data[k] = in_data[k] ^ (in_data[k] >> 1);
            end
        end
    end

    // Pipeline registers: {valid, mode, data/partial} per stage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                valid_q[k] <= 1'b0;
                mode_q[k]  <= 1'b0;
                data_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (load[k]) begin
                    valid_q[k] <= in_valid[k];
                    if (in_valid[k]) begin
                        mode_q[k] <= in_mode[k];
                        data_q[k] <= out_data[k];
                    end
                end
            end
        end
    end

    assign s_ready = load[0];
    assign m_valid = valid_q[STAGES-1];
    assign m_mode  = mode_q[STAGES-1];
    assign m_data  = data_q[STAGES-1];

`ifdef GREY_ADJ_CHECK_EN
    logic [WIDTH-1:0] ref_q;
    logic             ref_ok_q;
    logic [WIDTH-1:0] diff;

    assign diff = s_data ^ ref_q;

    // Sticky flag: more than one bit changed between consecutive accepted Gray->binary words.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ref_q    <= '0;
            ref_ok_q <= 1'b0;
            adj_err  <= 1'b0;
        end else if (s_valid && s_ready && s_mode) begin
            ref_q    <= s_data;
            ref_ok_q <= 1'b1;
            if (ref_ok_q && ((diff & (diff - WIDTH'(1))) != '0)) begin
                adj_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_grey_code_pipe.sv
// tb_grey_code_pipe: directed and scoreboard checks for grey_code_pipe (8/2 main instance plus
// 32/4, 7/3 and 6/6 sweep instances). adj_err checks are active when GREY_ADJ_CHECK_EN is defined.
module tb_grey_code_pipe;

    localparam int SW_N = 40;

    logic        clk = 1'b0;
    logic        resetn;

    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_mode;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_mode;

    logic        w_valid;
    logic [31:0] w_data;
    logic        w_mode;
    logic        w_mready;

    logic        a_ready, a_valid, a_mode;
    logic [31:0] a_data;
    logic        b_ready, b_valid, b_mode;
    logic [6:0]  b_data;
    logic        c_ready, c_valid, c_mode;
    logic [5:0]  c_data;

`ifdef GREY_ADJ_CHECK_EN
    logic        adj_err;
    logic        a_err, b_err, c_err;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [8:0]  sb_q[$];
    logic        hold_pending = 1'b0;
    logic [8:0]  hold_word;
    logic [31:0] sw_val  [SW_N];
    logic        sw_mode [SW_N];

    always #5 clk = ~clk;

    grey_code_pipe #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .resetn(resetn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_mode(s_mode),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_mode(m_mode)
`ifdef GREY_ADJ_CHECK_EN
        , .adj_err(adj_err)
`endif
    );

    grey_code_pipe #(.WIDTH(32), .STAGES(4)) dut_w32 (
        .clk(clk), .resetn(resetn),
        .s_valid(w_valid), .s_ready(a_ready), .s_data(w_data), .s_mode(w_mode),
        .m_valid(a_valid), .m_ready(w_mready), .m_data(a_data), .m_mode(a_mode)
`ifdef GREY_ADJ_CHECK_EN
        , .adj_err(a_err)
`endif
    );

    grey_code_pipe #(.WIDTH(7), .STAGES(3)) dut_w7 (
        .clk(clk), .resetn(resetn),
        .s_valid(w_valid), .s_ready(b_ready), .s_data(w_data[6:0]), .s_mode(w_mode),
        .m_valid(b_valid), .m_ready(w_mready), .m_data(b_data), .m_mode(b_mode)
`ifdef GREY_ADJ_CHECK_EN
        , .adj_err(b_err)
`endif
    );

    grey_code_pipe #(.WIDTH(6), .STAGES(6)) dut_w6 (
        .clk(clk), .resetn(resetn),
        .s_valid(w_valid), .s_ready(c_ready), .s_data(w_data[5:0]), .s_mode(w_mode),
        .m_valid(c_valid), .m_ready(w_mready), .m_data(c_data), .m_mode(c_mode)
`ifdef GREY_ADJ_CHECK_EN
        , .adj_err(c_err)
`endif
    );

    // Reference models (narrow words are passed zero-extended).
    function automatic logic [31:0] b2g(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] g2b(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int s = 1; s < 32; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [31:0] conv(input logic m, input logic [31:0] v);
        return m ? g2b(v) : b2g(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One isolated beat on the 8/2 instance with exact two-cycle latency; starts and ends on a posedge.
    task automatic send_one(input string tag, input logic md, input logic [7:0] d, input logic [7:0] exp);
        #1;
        s_valid = 1'b1; s_data = d; s_mode = md; m_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        check({tag, "_early"}, 32'(m_valid), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 32'(m_valid), 32'd1);
        check({tag, "_data"}, 32'(m_data), 32'(exp));
        check({tag, "_mode"}, 32'(m_mode), 32'(md));
        @(posedge clk);
    endtask

    // One scoreboarded cycle on the 8/2 instance; starts and ends on a posedge.
    task automatic step(input logic sv, input logic [7:0] sd, input logic sm, input logic mr,
                        input logic exp_stall);
        logic [8:0] exp_w;
        #1;
        s_valid = sv; s_data = sd; s_mode = sm; m_ready = mr;
        @(negedge clk);
        if (exp_stall) check("bp_s_ready", 32'(s_ready), 32'd0);
        if (hold_pending) begin
            check("hold_valid", 32'(m_valid), 32'd1);
            check("hold_word", 32'({m_mode, m_data}), 32'(hold_word));
        end
        hold_pending = m_valid && !m_ready;
        hold_word    = {m_mode, m_data};
        if (s_valid && s_ready) sb_q.push_back({s_mode, 8'(conv(s_mode, 32'(s_data)))});
        if (m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_extra_beat", 32'({m_mode, m_data}), 32'h1ff);
            end else begin
                exp_w = sb_q.pop_front();
                check("sb_beat", 32'({m_mode, m_data}), 32'(exp_w));
            end
        end
        @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        s_valid = 1'b0; s_data = '0; s_mode = 1'b0; m_ready = 1'b1;
        w_valid = 1'b0; w_data = '0; w_mode = 1'b0; w_mready = 1'b1;
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_mode", 32'(m_mode), 32'd0);
`ifdef GREY_ADJ_CHECK_EN
        check("rst_adj_err", 32'(adj_err), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd1);
        @(posedge clk);

        // Directed single beats.
        send_one("b2g_5a", 1'b0, 8'h5A, 8'h77);
        send_one("g2b_77", 1'b1, 8'h77, 8'h5A);
        send_one("g2b_80", 1'b1, 8'h80, 8'hFF);
        send_one("b2g_ff", 1'b0, 8'hFF, 8'h80);
        send_one("b2g_00", 1'b0, 8'h00, 8'h00);
        send_one("g2b_00", 1'b1, 8'h00, 8'h00);

        // Back-to-back streams: all binary values to Gray, then all Gray codes back to binary.
        for (int md = 0; md < 2; md++) begin
            for (int c = 0; c < 258; c++) begin
                #1;
                s_valid = (c < 256);
                s_mode  = md[0];
                s_data  = md[0] ? 8'(b2g(32'(c & 255))) : 8'(c);
                m_ready = 1'b1;
                #1;
                if (c < 256) check("stream_rdy", 32'(s_ready), 32'd1);
                if (c >= 2) begin
                    check("stream_valid", 32'(m_valid), 32'd1);
                    check("stream_data", 32'(m_data), md[0] ? 32'(c - 2) : b2g(32'(c - 2)));
                    check("stream_mode", 32'(m_mode), 32'(md));
                end
                @(posedge clk);
            end
        end

        // Backpressure: m_ready low for five cycles with the input held busy.
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 8'(8'h40 + c), c[0], !(c >= 3 && c < 8), (c >= 3 && c < 8));
        end
        repeat (4) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("bp_drained", 32'(sb_q.size()), 32'd0);

        // Random traffic against the scoreboard, mixed modes.
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), 1'b0);
        end
        repeat (4) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("rand_drained", 32'(sb_q.size()), 32'd0);

        // Reset with two beats in flight.
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
        #2;
        s_valid = 1'b0;
        check("pre_rst_valid", 32'(m_valid), 32'd1);
        resetn = 1'b0;
        #1;
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_m_data", 32'(m_data), 32'd0);
        check("midrst_m_mode", 32'(m_mode), 32'd0);
        sb_q.delete();
        hold_pending = 1'b0;
        #2 resetn = 1'b1;
        @(posedge clk);
        send_one("post_rst_5a", 1'b0, 8'h5A, 8'h77);

`ifdef GREY_ADJ_CHECK_EN
        // Adjacency check on Gray->binary inputs.
        send_one("adj_00", 1'b1, 8'h00, 8'h00);
        check("adj_after_00", 32'(adj_err), 32'd0);
        send_one("adj_01", 1'b1, 8'h01, 8'h01);
        check("adj_after_01", 32'(adj_err), 32'd0);
        send_one("adj_03", 1'b1, 8'h03, 8'h02);
        check("adj_after_03", 32'(adj_err), 32'd0);
        send_one("adj_b2g_ff", 1'b0, 8'hFF, 8'h80);
        check("adj_after_b2g", 32'(adj_err), 32'd0);
        send_one("adj_same_03", 1'b1, 8'h03, 8'h02);
        check("adj_after_same", 32'(adj_err), 32'd0);
        send_one("adj_jump_00", 1'b1, 8'h00, 8'h00);
        check("adj_after_jump", 32'(adj_err), 32'd1);
        send_one("adj_b2g_55", 1'b0, 8'h55, 8'h7F);
        check("adj_sticky", 32'(adj_err), 32'd1);
`endif

        // Wide/odd-slice sweep: boundary words first, then random values and modes.
        sw_val[0] = 32'h0000_0000; sw_mode[0] = 1'b0;
        sw_val[1] = 32'hFFFF_FFFF; sw_mode[1] = 1'b0;
        sw_val[2] = 32'h8000_0000; sw_mode[2] = 1'b1;
        sw_val[3] = 32'h0000_0000; sw_mode[3] = 1'b1;
        sw_val[4] = 32'h0000_0040; sw_mode[4] = 1'b1;
        sw_val[5] = 32'h0000_0020; sw_mode[5] = 1'b1;
        for (int i = 6; i < SW_N; i++) begin
            sw_val[i]  = $urandom;
            sw_mode[i] = 1'($urandom_range(0, 1));
        end
        for (int c = 0; c < SW_N + 6; c++) begin
            #1;
            w_valid = (c < SW_N);
            if (c < SW_N) begin
                w_data = sw_val[c];
                w_mode = sw_mode[c];
            end
            #1;
            if (c < SW_N) begin
                check("w32_rdy", 32'(a_ready), 32'd1);
                check("w7_rdy", 32'(b_ready), 32'd1);
                check("w6_rdy", 32'(c_ready), 32'd1);
            end
            if (c >= 4 && c < SW_N + 4) begin
                check("w32_valid", 32'(a_valid), 32'd1);
                check("w32_data", a_data, conv(sw_mode[c-4], sw_val[c-4]));
                check("w32_mode", 32'(a_mode), 32'(sw_mode[c-4]));
            end
            if (c >= 3 && c < SW_N + 3) begin
                check("w7_valid", 32'(b_valid), 32'd1);
                check("w7_data", 32'(b_data), conv(sw_mode[c-3], sw_val[c-3] & 32'h7F));
            end
            if (c >= 6 && c < SW_N + 6) begin
                check("w6_valid", 32'(c_valid), 32'd1);
                check("w6_data", 32'(c_data), conv(sw_mode[c-6], sw_val[c-6] & 32'h3F));
            end
            @(posedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
